// File: rtl/mux_channel_scanner_if.sv
// Signal bundle between the channel scanner and its environment: the mux-side
// select/return pair, the scan controls and the frame result. The master
// modport drives the scanner, and the slave modport is the scanner itself.
// Handshake: frame_valid is a one-cycle pulse with no ready. The consumer
// must capture frame in the cycle frame_valid is high. frame then holds its
// value until the next pulse.
interface mux_channel_scanner_if;
  logic       start;
  logic       cont;
  logic       y;
  logic [1:0] s;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;
  logic [7:0] frame_count;
  logic [1:0] state;

  modport master (
    output start, cont, y,
    input  s, busy, frame, frame_valid, frame_count, state
  );

  modport slave (
    input  start, cont, y,
    output s, busy, frame, frame_valid, frame_count, state
  );
endinterface

// File: rtl/mux_channel_scanner.sv
// Scans a 4-to-1 mux through channels 0..3. On each channel it waits DWELL
// settle cycles and then samples y. The four samples are published as one
// frame with a single-cycle frame_valid pulse. The FSM state is exported on
// bus.state for observation.
module mux_channel_scanner #(
  parameter int DWELL = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux_channel_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state, state_next;
  logic [1:0] ch, ch_next;
  logic [7:0] dwell_cnt, dwell_cnt_next;
  logic [2:0] shadow, shadow_next;
  logic [3:0] frame, frame_next;
  logic [7:0] frame_count, frame_count_next;

  // State and datapath registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= 2'd0;
      dwell_cnt   <= 8'd0;
      shadow      <= 3'd0;
      frame       <= 4'd0;
      frame_count <= 8'd0;
    end else begin
      state       <= state_next;
      ch          <= ch_next;
      dwell_cnt   <= dwell_cnt_next;
      shadow      <= shadow_next;
      frame       <= frame_next;
      frame_count <= frame_count_next;
    end
  end

  // Next-state and datapath update; frame and shadow change only in SAMPLE
  always_comb begin
    state_next       = state;
    ch_next          = ch;
    dwell_cnt_next   = dwell_cnt;
    shadow_next      = shadow;
    frame_next       = frame;
    frame_count_next = frame_count;
    case (state)
      IDLE: begin
        ch_next        = 2'd0;
        dwell_cnt_next = 8'd0;
        if (bus.start) state_next = SETTLE;
      end
      SETTLE: begin
        dwell_cnt_next = dwell_cnt + 8'd1;
        if (dwell_cnt == DWELL_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (ch != 2'd3) begin
          shadow_next[ch] = bus.y;
          ch_next         = ch + 2'd1;
          dwell_cnt_next  = 8'd0;
          state_next      = SETTLE;
        end else begin
          // The whole frame is committed at once, so it is never partially updated
          frame_next       = {bus.y, shadow};
          frame_count_next = frame_count + 8'd1;
          state_next       = DONE;
        end
      end
      DONE: begin
        ch_next        = 2'd0;
        dwell_cnt_next = 8'd0;
        state_next     = bus.cont ? SETTLE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from registers only, so no input reaches an output combinationally
  assign bus.s           = ch;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_valid = (state == DONE);
  assign bus.frame       = frame;
  assign bus.frame_count = frame_count;
  assign bus.state       = state;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner. It runs one DWELL=4 instance and one
// DWELL=1 instance, each closing the loop through a behavioural 4-to-1 mux.
module tb_mux_channel_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] mux4_i;
  logic [3:0] mux1_i;
  int         checks;
  int         errors;
  int         n;

  mux_channel_scanner_if bus4();
  mux_channel_scanner_if bus1();

  // Behavioural muxes: y = I[s]
  assign bus4.y = mux4_i[bus4.s];
  assign bus1.y = mux1_i[bus1.s];

  mux_channel_scanner #(.DWELL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_channel_scanner #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Clock and timeout guard
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  // Count edges until frame_valid on the DWELL=4 instance, bounded by budget
  task automatic wait_fv4(input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      step(1);
      edges++;
      if (bus4.frame_valid) break;
    end
    check("fv4_seen", 32'(bus4.frame_valid), 32'd1);
  endtask

  // One single-shot frame on the DWELL=4 instance with pulse timing checks
  task automatic scan_once(input logic [3:0] i_val);
    mux4_i = i_val;
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    step(19);
    check("once_fv_early", 32'(bus4.frame_valid), 32'd0);
    step(1);
    check("once_fv", 32'(bus4.frame_valid), 32'd1);
    check("once_frame", 32'(bus4.frame), 32'(i_val));
    step(1);
    check("once_fv_drop", 32'(bus4.frame_valid), 32'd0);
    check("once_idle", 32'(bus4.busy), 32'd0);
    check("once_hold", 32'(bus4.frame), 32'(i_val));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mux4_i = 4'b0000;
    mux1_i = 4'b0000;
    bus4.start = 1'b0;
    bus4.cont  = 1'b0;
    bus1.start = 1'b0;
    bus1.cont  = 1'b0;

    // Reset state
    step(2);
    check("rst_s", 32'(bus4.s), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_frame", 32'(bus4.frame), 32'd0);
    check("rst_fv", 32'(bus4.frame_valid), 32'd0);
    check("rst_count", 32'(bus4.frame_count), 32'd0);
    rst = 1'b0;
    step(1);
    check("idle_busy", 32'(bus4.busy), 32'd0);

    // Basic scan with I=1010; s walks 0..3 holding each channel 5 cycles
    mux4_i = 4'b1010;
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    check("basic_busy", 32'(bus4.busy), 32'd1);
    for (int k = 0; k < 20; k++) begin
      check("basic_s", 32'(bus4.s), 32'(k / 5));
      check("basic_fv_low", 32'(bus4.frame_valid), 32'd0);
      step(1);
    end
    check("basic_fv", 32'(bus4.frame_valid), 32'd1);
    check("basic_frame", 32'(bus4.frame), 32'hA);
    check("basic_count", 32'(bus4.frame_count), 32'd1);
    step(1);
    check("basic_fv_one", 32'(bus4.frame_valid), 32'd0);
    check("basic_idle", 32'(bus4.busy), 32'd0);
    check("basic_s_idle", 32'(bus4.s), 32'd0);

    // New input pattern between frames
    scan_once(4'b0101);
    check("once_count", 32'(bus4.frame_count), 32'd2);

    // Continuous mode: 0000 -> 1111 -> 0110, cont dropped mid third frame
    mux4_i = 4'b0000;
    bus4.cont = 1'b1;
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    wait_fv4(40, n);
    check("cont_gap1", 32'(n), 32'd20);
    check("cont_frame1", 32'(bus4.frame), 32'h0);
    mux4_i = 4'b1111;
    wait_fv4(40, n);
    check("cont_gap2", 32'(n), 32'd21);
    check("cont_frame2", 32'(bus4.frame), 32'hF);
    mux4_i = 4'b0110;
    step(5);
    bus4.cont = 1'b0;
    check("cont_busy_mid", 32'(bus4.busy), 32'd1);
    wait_fv4(40, n);
    check("cont_gap3", 32'(n), 32'd16);
    check("cont_frame3", 32'(bus4.frame), 32'h6);
    check("cont_count", 32'(bus4.frame_count), 32'd5);
    step(1);
    check("cont_idle", 32'(bus4.busy), 32'd0);

    // Start while busy: pulses at E0+7 and in DONE are ignored
    mux4_i = 4'b0011;
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    step(7);
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    wait_fv4(40, n);
    check("busy_gap", 32'(n), 32'd12);
    check("busy_frame", 32'(bus4.frame), 32'h3);
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    check("busy_done_idle", 32'(bus4.busy), 32'd0);
    check("busy_count", 32'(bus4.frame_count), 32'd6);
    step(25);
    check("busy_no_restart", 32'(bus4.busy), 32'd0);
    check("busy_count_hold", 32'(bus4.frame_count), 32'd6);

    // Reset mid-scan at E0+12
    mux4_i = 4'b1001;
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    step(12);
    check("mid_s_before", 32'(bus4.s), 32'd2);
    rst = 1'b1;
    step(1);
    check("mid_rst_s", 32'(bus4.s), 32'd0);
    check("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check("mid_rst_frame", 32'(bus4.frame), 32'd0);
    check("mid_rst_count", 32'(bus4.frame_count), 32'd0);
    check("mid_rst_fv", 32'(bus4.frame_valid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("mid_no_fv", 32'(bus4.frame_valid), 32'd0);
    end
    scan_once(4'b1100);
    check("mid_count", 32'(bus4.frame_count), 32'd1);

    // 256 back-to-back frames: frame_count wraps 255 -> 0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mux4_i = 4'b1001;
    bus4.cont = 1'b1;
    bus4.start = 1'b1;
    step(1);
    bus4.start = 1'b0;
    for (int f = 1; f <= 256; f++) begin
      wait_fv4(40, n);
      check("wrap_gap", 32'(n), (f == 1 || f == 256) ? 32'd20 : 32'd21);
      check("wrap_count", 32'(bus4.frame_count), 32'(f % 256));
      if (f == 255) begin
        step(1);
        bus4.cont = 1'b0;
      end
    end
    check("wrap_frame", 32'(bus4.frame), 32'h9);
    step(1);
    check("wrap_idle", 32'(bus4.busy), 32'd0);

    // DWELL=1: frame_valid at E0+8, each channel held 2 cycles
    check("d1_count0", 32'(bus1.frame_count), 32'd0);
    mux1_i = 4'b0110;
    bus1.start = 1'b1;
    step(1);
    bus1.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("d1_s", 32'(bus1.s), 32'(k / 2));
      check("d1_fv_low", 32'(bus1.frame_valid), 32'd0);
      step(1);
    end
    check("d1_fv", 32'(bus1.frame_valid), 32'd1);
    check("d1_frame", 32'(bus1.frame), 32'h6);
    check("d1_count", 32'(bus1.frame_count), 32'd1);
    step(1);
    check("d1_idle", 32'(bus1.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
